// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM interface: RAM handshake states, the
// machine word, and the arbiter grant states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache word requests onto a single-ported RAM.
// Data wins by default; after I_STARVE_MAX consecutive data completions
// with an instruction fetch pending, the instruction side gets one word.
// RAM ERROR responses are retried in place up to ERR_RETRY_MAX times, after
// which the access is completed anyway and a sticky fault is raised.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int I_STARVE_MAX  = 4,
    parameter int ERR_RETRY_MAX = 3
) (
    input  logic              CLK,
    input  logic              RST,
    // instruction cache
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    // data cache
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    // RAM
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    // status
    output logic              mem_fault
);

    localparam int SW = $clog2(I_STARVE_MAX + 1);
    localparam int RW = $clog2(ERR_RETRY_MAX + 1);

    localparam logic [SW-1:0] STARVE_LIM = SW'(I_STARVE_MAX);
    // An ERROR seen while the counter sits here is the last allowed retry.
    localparam logic [RW-1:0] RETRY_LAST = RW'(ERR_RETRY_MAX - 1);

    arb_state_t    state, state_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic [RW-1:0] retry_cnt, retry_nx;

    ramstate_t ram_st;
    logic      d_req;
    logic      grant_live;
    logic      err_last;
    logic      done;

    assign ram_st = ramstate_t'(ramstate);
    assign d_req  = dREN | dWEN;

    // The granted requester still wants its word; if not, the grant is abandoned.
    assign grant_live = ((state == DGRANT) && d_req) || ((state == IGRANT) && iREN);
    assign err_last   = (ram_st == ERROR) && (retry_cnt == RETRY_LAST);
    assign done       = grant_live && ((ram_st == ACCESS) || err_last);

    // Priority decision shared by IDLE and by every completion edge.
    function automatic arb_state_t arbitrate(input logic i_r, input logic d_r,
                                             input logic [SW-1:0] starve);
        if (d_r && (starve < STARVE_LIM)) return DGRANT;
        else if (i_r)                     return IGRANT;
        else if (d_r)                     return DGRANT;
        else                              return IDLE;
    endfunction

    // Next-state, starvation and retry bookkeeping.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nx  = state;
        starve_nx = starve_cnt;
        retry_nx  = retry_cnt;

        if (!iREN)
            starve_nx = '0;
        else if (done && (state == IGRANT))
            starve_nx = '0;
        else if (done && (state == DGRANT) && (starve_cnt != STARVE_LIM))
            starve_nx = starve_cnt + SW'(1);

        if (state == IDLE) begin
            state_nx = arbitrate(iREN, d_req, starve_nx);
        end else if (!grant_live) begin
            state_nx = IDLE;
            retry_nx = '0;
        end else if (done) begin
            // Straight into the next grant: no idle cycle between words.
            state_nx = arbitrate(iREN, d_req, starve_nx);
            retry_nx = '0;
        end else if (ram_st == ERROR) begin
            retry_nx = retry_cnt + RW'(1);
        end
    end

    // Registered grant, counters and sticky fault flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            retry_cnt  <= '0;
            mem_fault  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nx;
            starve_cnt <= starve_nx;
            retry_cnt  <= retry_nx;
            if (done && err_last)
                mem_fault <= 1'b1;
        end
    end

    // RAM drive follows the registered grant and the live request lines, so a
    // withdrawn request or an asynchronous reset drops the enables at once.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
            end
            default: ;
        endcase
    end

    assign iwait = ~(done && (state == IGRANT));
    assign dwait = ~(done && (state == DGRANT));
    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared each cycle against a
// transaction-level model of the arbitration rules.
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int RMAX = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          iREN, dREN, dWEN;
    logic [AW-1:0] iaddr, daddr, ramaddr;
    logic [DW-1:0] dstore, ramload, iload, dload, ramstore;
    logic          iwait, dwait, ramREN, ramWEN, mem_fault;
    logic [1:0]    ramstate;

    cache_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .I_STARVE_MAX(SMAX), .ERR_RETRY_MAX(RMAX)
    ) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_fault(mem_fault)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = nobody, 1 = data cache, 2 = instruction cache
    int  m_owner  = 0;
    int  m_starve = 0;
    int  m_retry  = 0;
    bit  m_fault  = 0;

    function automatic int pick(input bit i_r, input bit d_r, input int starve);
        if (d_r && starve < SMAX) return 1;
        if (i_r)                  return 2;
        if (d_r)                  return 1;
        return 0;
    endfunction

    initial begin : model
        bit            dreq, live, fin, e_ren, e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_store;
        forever begin
            @(negedge CLK);
            if (RST) begin
                m_owner = 0; m_starve = 0; m_retry = 0; m_fault = 0;
                check("m_rst_ramREN", ramREN, 0);
                check("m_rst_ramWEN", ramWEN, 0);
                check("m_rst_ramaddr", ramaddr, 0);
                check("m_rst_iwait", iwait, 1);
                check("m_rst_dwait", dwait, 1);
                check("m_rst_fault", mem_fault, 0);
            end else begin
                dreq    = dREN | dWEN;
                live    = (m_owner == 1 && dreq) || (m_owner == 2 && iREN);
                e_ren   = 0; e_wen = 0; e_addr = '0; e_store = '0;
                if (m_owner == 1) begin
                    e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN && !dWEN;
                end else if (m_owner == 2) begin
                    e_addr = iaddr; e_ren = iREN;
                end
                fin = live && (ramstate == 2'(ACCESS) ||
                               (ramstate == 2'(ERROR) && m_retry + 1 == RMAX));
                check("m_ramREN", ramREN, e_ren);
                check("m_ramWEN", ramWEN, e_wen);
                check("m_ramaddr", ramaddr, e_addr);
                check("m_ramstore", ramstore, e_store);
                check("m_iwait", iwait, !(fin && m_owner == 2));
                check("m_dwait", dwait, !(fin && m_owner == 1));
                check("m_fault", mem_fault, m_fault);
                if (fin && m_owner == 2) check("m_iload", iload, ramload);
                if (fin && m_owner == 1) check("m_dload", dload, ramload);
                // advance to the state the next edge will produce
                if (fin && ramstate == 2'(ERROR)) m_fault = 1;
                if (!iREN)                                    m_starve = 0;
                else if (fin && m_owner == 2)                 m_starve = 0;
                else if (fin && m_owner == 1 && m_starve < SMAX) m_starve++;
                if (m_owner != 0) begin
                    if (!live || fin)              m_retry = 0;
                    else if (ramstate == 2'(ERROR)) m_retry++;
                end
                if (m_owner == 0 || fin) m_owner = pick(iREN, dreq, m_starve);
                else if (!live)          m_owner = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        bit [9:0] ipat, dpat;
        bit       got;
        int       r;
        iREN = 0; dREN = 0; dWEN = 0; iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'(FREE);

        // reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_fault", mem_fault, 0);
        RST = 0;

        // single icache read: BUSY, BUSY, ACCESS
        iREN = 1; iaddr = 32'h40;
        tick(); ramstate = 2'(BUSY); #2;
        check("i1_ren", ramREN, 1); check("i1_addr", ramaddr, 32'h40); check("i1_iwait", iwait, 1);
        tick(); #2;
        check("i2_ren", ramREN, 1); check("i2_iwait", iwait, 1);
        tick(); ramstate = 2'(ACCESS); ramload = 32'h2402000A; #2;
        check("i3_iwait", iwait, 0); check("i3_iload", iload, 32'h2402000A);
        check("i3_dwait", dwait, 1); check("i3_addr", ramaddr, 32'h40);
        tick(); iREN = 0; ramstate = 2'(FREE); #2;
        check("i4_ren_drop", ramREN, 0); check("i4_iwait", iwait, 1);
        tick();

        // simultaneous requests: data first, then instruction
        iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h80; ramstate = 2'(BUSY);
        tick(); #2;
        check("sim_d_first_addr", ramaddr, 32'h80); check("sim_d_first_ren", ramREN, 1);
        check("sim_iwait", iwait, 1);
        tick(); ramstate = 2'(ACCESS); ramload = 32'h1234; #2;
        check("sim_dwait", dwait, 0); check("sim_dload", dload, 32'h1234); check("sim_iwait2", iwait, 1);
        tick(); dREN = 0; ramstate = 2'(BUSY);
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            tick(); #2;
            if (ramREN && ramaddr == 32'h44) got = 1;
        end
        check("sim_igrant_follows", got, 1);
        ramstate = 2'(ACCESS); #1;
        check("sim_i_done", iwait, 0);
        tick(); iREN = 0; ramstate = 2'(FREE);
        tick();

        // starvation bound: data write held, instruction held, RAM always ACCESS
        iREN = 1; iaddr = 32'h100; dWEN = 1; daddr = 32'h200; dstore = 32'h55;
        ramstate = 2'(ACCESS);
        for (int k = 0; k < 10; k++) begin
            tick(); ramload = 32'(k); #2;
            ipat[k] = ~iwait;
            dpat[k] = ~dwait;
            if (k == 4) check("stv_i_addr", ramaddr, 32'h100);
            if (k == 5) check("stv_cnt_clear", dut.starve_cnt, 0);
        end
        check("stv_i_pattern", ipat, 10'h210);
        check("stv_d_pattern", dpat, 10'h1EF);
        tick(); iREN = 0; dWEN = 0; ramstate = 2'(FREE);
        tick(); tick();

        // write path, write wins over read
        dWEN = 1; dREN = 1; daddr = 32'h3100; dstore = 32'h1C; ramstate = 2'(BUSY);
        tick(); #2;
        check("wr_wen", ramWEN, 1); check("wr_ren", ramREN, 0);
        check("wr_store", ramstore, 32'h1C); check("wr_addr", ramaddr, 32'h3100);
        check("wr_dwait_busy", dwait, 1);
        tick(); ramstate = 2'(ACCESS); #2;
        check("wr_dwait", dwait, 0);
        tick(); dWEN = 0; dREN = 0; ramstate = 2'(FREE);
        tick();

        // error retry: three ERRORs on an instruction fetch
        iREN = 1; iaddr = 32'h60; ramstate = 2'(ERROR);
        tick(); #2;
        check("err1_iwait", iwait, 1); check("err1_fault", mem_fault, 0);
        tick(); #2;
        check("err2_iwait", iwait, 1);
        tick(); ramload = 32'hDEADBEEF; #2;
        check("err3_iwait", iwait, 0); check("err3_iload", iload, 32'hDEADBEEF);
        tick(); iREN = 0; ramstate = 2'(FREE); #2;
        check("err_fault_set", mem_fault, 1);
        tick();
        dREN = 1; daddr = 32'h84; ramstate = 2'(ERROR);
        tick(); #2;
        check("err_d1_dwait", dwait, 1);
        tick(); ramstate = 2'(ACCESS); ramload = 32'h77; #2;
        check("err_d2_dwait", dwait, 0); check("err_d2_dload", dload, 32'h77);
        tick(); dREN = 0; ramstate = 2'(FREE); #2;
        check("err_retry_clear", dut.retry_cnt, 0);
        check("err_fault_sticky", mem_fault, 1);
        tick();

        // abort mid-BUSY
        dREN = 1; daddr = 32'h90; ramstate = 2'(BUSY);
        tick(); #2;
        check("ab_ren", ramREN, 1);
        tick(); dREN = 0; #1;
        check("ab_ren_drop", ramREN, 0); check("ab_dwait", dwait, 1);
        tick(); #2;
        check("ab_idle", 64'(dut.state), 64'(IDLE));

        // asynchronous reset mid-IGRANT
        iREN = 1; iaddr = 32'h70; ramstate = 2'(BUSY);
        tick(); #2;
        check("rs_ren", ramREN, 1);
        RST = 1; #1;
        check("rs_ren_drop", ramREN, 0); check("rs_iwait", iwait, 1);
        check("rs_fault_clr", mem_fault, 0);
        tick(); RST = 0; iREN = 0; ramstate = 2'(FREE);
        tick();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            RST = ($urandom_range(199) == 0);
            if ($urandom_range(9) < 2)  iREN = ~iREN;
            if ($urandom_range(99) < 15) dREN = ~dREN;
            if ($urandom_range(99) < 15) dWEN = ~dWEN;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(99);
            if (r < 40)      ramstate = 2'(ACCESS);
            else if (r < 70) ramstate = 2'(BUSY);
            else if (r < 85) ramstate = 2'(FREE);
            else             ramstate = 2'(ERROR);
        end
        tick(); RST = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches. Arbitrates their miss/writeback word requests onto the single-ported RAM.
- Grant is registered and held until RAM reports the access complete.
- Data requests have priority; a starvation bound guarantees instruction fetch progress.
- Completion is signalled back to each cache by dropping its wait line for exactly one cycle per word.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, word width
- I_STARVE_MAX, 4, consecutive data grants allowed while an instruction request waits
- ERR_RETRY_MAX, 3, retries per request on RAM ERROR before flagging fault

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache word address
- iwait  out  1  0 = iload valid this cycle
- iload  out  DATA_W  instruction word
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache word address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  0 = dcache access completes this cycle
- dload  out  DATA_W  data word
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_fault  out  1  sticky; retries exhausted

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-high.
- Reset values: state=IDLE, starve_cnt=0, retry_cnt=0, mem_fault=0, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- States: IDLE, DGRANT, IGRANT.
- IDLE, arbitration (evaluated at each clock edge):
  - If (dREN|dWEN) and starve_cnt<I_STARVE_MAX, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else if (dREN|dWEN), go to DGRANT.
  - Else stay in IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN. If both dREN and dWEN are high, the write wins.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
- RAM outputs are combinational from the registered grant plus the live request inputs.
- Completion: in the granted state with ramstate==ACCESS:
  - The granted wait line is 0 for that cycle; the other wait line stays 1.
  - iload/dload = ramload combinationally. iload/dload are don't-care when their wait line is 1.
  - At the edge, re-arbitrate using the IDLE rules, going straight to the next grant with no bubble.
- starve_cnt:
  - Increments on each DGRANT completion while iREN=1; saturates at I_STARVE_MAX.
  - Clears on IGRANT completion, or whenever iREN=0.
- BUSY/FREE in a granted state: hold the grant; wait lines stay 1.
- ERROR in a granted state:
  - Hold the grant and reissue; wait lines stay 1; retry_cnt++.
  - When retry_cnt reaches ERR_RETRY_MAX: set mem_fault=1, complete the access (wait=0, data = ramload as-is), clear retry_cnt.
  - retry_cnt also clears on every normal completion.
- Request withdrawn mid-grant (granted requester's enables fall, e.g. cache reset or halt): drop the RAM enables combinationally and return to IDLE at the next edge; no completion is signalled.
- Back-to-back: a requester holding its enable through completion is re-granted next cycle if arbitration allows. Every word costs at least one full RAM handshake.
- Reset asserted mid-access: asynchronous return to the reset values. The RAM sees the enables drop immediately.
- Width rule: starve_cnt is $clog2(I_STARVE_MAX+1) bits; retry_cnt is $clog2(ERR_RETRY_MAX+1) bits.

Decomposition:
- Shared package (cpu_types_pkg): ramstate_t enum (FREE, BUSY, ACCESS, ERROR), word_t, arb_state_t (IDLE, DGRANT, IGRANT).
- No sub-module; the arbitration priority function is a local function.

Test Plan:
- Single icache read: iREN=1, iaddr=0x40; RAM BUSY 2 cycles then ACCESS with ramload=0x2402000A -> ramREN=1, ramaddr=0x40 throughout; iwait=0 only on the ACCESS cycle, iload=0x2402000A; dwait stays 1.
- Simultaneous requests: iREN=1 and dREN=1 (daddr=0x80) in the same cycle -> DGRANT first; IGRANT follows immediately after the data ACCESS with no idle cycle.
- Starvation bound with I_STARVE_MAX=4: dWEN held, iREN held -> exactly 4 data completions, then 1 instruction completion, then data resumes; starve_cnt returns to 0.
- Write path: dWEN=1, daddr=0x3100, dstore=0x0000001C -> ramWEN=1, ramREN=0, ramstore=0x1C; dwait=0 on ACCESS. With dREN=1 also high, ramREN remains 0.
- Error retry: ramstate=ERROR 3 consecutive cycles during IGRANT -> the third error completes with iwait=0 and mem_fault=1 (sticky until RST). A following request with a single ERROR then ACCESS leaves retry_cnt=0 after completion.
- Abort and reset: dREN falls mid-BUSY -> ramREN=0 the same cycle, IDLE next edge, dwait never 0. Assert RST mid-IGRANT -> ramREN=0 and iwait=1 immediately, without waiting for an edge.
